// File: rtl/ev22_pkg.sv
// ---------------------------------------------------------------------------
// ev22_pkg
// Shared definitions for the instruction fetch unit:
//   - fetch_state_t    : fetch FSM state encoding
//   - RESET_PC_DEFAULT : default first fetch address after reset
//   - PC_INC_DEFAULT   : default sequential PC increment (bytes)
// ---------------------------------------------------------------------------
package ev22_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          PC_INC_DEFAULT   = 4;

endpackage

// File: rtl/pc_fetch_adder.sv
// ---------------------------------------------------------------------------
// adder
// Plain WIDTH-bit adder used for the sequential PC increment. The carry out
// is dropped, so the sum wraps modulo 2^WIDTH.
// Ports:
//   a   in  WIDTH  first operand
//   b   in  WIDTH  second operand
//   sum out WIDTH  a + b (mod 2^WIDTH)
// ---------------------------------------------------------------------------
module adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/pc_fetch.sv
// ---------------------------------------------------------------------------
// pc_fetch
// Instruction fetch unit: issues one instruction-memory request at a time,
// forwards each returned word with its address toward decode, and handles
// branch/jump redirects, discarding a response that belongs to a fetch
// made obsolete by a redirect.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   redirect_valid/_pc     redirect request and target (word aligned here)
//   imem_req_valid/_ready  request handshake toward instruction memory
//   imem_req_addr          fetch address
//   imem_rsp_valid/_data   in-order response from instruction memory
//   out_valid/_ready       handshake toward decode
//   out_pc, out_instr      fetched instruction and its address
// All outputs come from registers or from the state register only.
// ---------------------------------------------------------------------------
module pc_fetch
    import ev22_pkg::*;
#(
    parameter int                   BUS_WIDTH = 32,
    parameter logic [BUS_WIDTH-1:0] RESET_PC  = BUS_WIDTH'(RESET_PC_DEFAULT),
    parameter int                   PC_INC    = PC_INC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 redirect_valid,
    input  logic [BUS_WIDTH-1:0] redirect_pc,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [BUS_WIDTH-1:0] imem_req_addr,
    input  logic                 imem_rsp_valid,
    input  logic [31:0]          imem_rsp_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BUS_WIDTH-1:0] out_pc,
    output logic [31:0]          out_instr
);

    localparam logic [BUS_WIDTH-1:0] INC_VAL    = BUS_WIDTH'(PC_INC);
    localparam logic [BUS_WIDTH-1:0] ALIGN_MASK = {{(BUS_WIDTH-2){1'b1}}, 2'b00};

    fetch_state_t         state_q;
    fetch_state_t         state_d;
    logic [BUS_WIDTH-1:0] pc_q;
    logic [BUS_WIDTH-1:0] inflight_pc;
    logic [BUS_WIDTH-1:0] pc_next;
    logic [BUS_WIDTH-1:0] redirect_aligned;
    logic                 req_fire;
    logic                 redirect_act;

    adder #(
        .WIDTH(BUS_WIDTH)
    ) u_pc_adder (
        .a  (pc_q),
        .b  (INC_VAL),
        .sum(pc_next)
    );

    assign redirect_aligned = redirect_pc & ALIGN_MASK;
    assign imem_req_valid   = (state_q == ST_REQ);
    assign imem_req_addr    = pc_q;
    assign req_fire         = imem_req_valid && imem_req_ready;
    // Redirects are meaningless before the first fetch has started.
    assign redirect_act     = redirect_valid && (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (redirect_valid) begin
                    // An accepted request still owes us a response to drop.
                    state_d = req_fire ? ST_DRAIN : ST_REQ;
                end else if (req_fire) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    // If the response arrives in the redirect cycle it is the
                    // one being discarded; waiting for another would hang.
                    state_d = imem_rsp_valid ? ST_REQ : ST_DRAIN;
                end else if (imem_rsp_valid) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect_valid || out_ready) begin
                    state_d = ST_REQ;
                end
            end
            ST_DRAIN: begin
                // A further redirect only moves pc_q; the stale response is
                // still the event that ends the drain.
                if (imem_rsp_valid) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            inflight_pc <= '0;
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_instr   <= '0;
        end else begin
            state_q <= state_d;
            if (req_fire) begin
                inflight_pc <= pc_q;
                pc_q        <= pc_next;
            end
            if ((state_q == ST_WAIT) && imem_rsp_valid && !redirect_valid) begin
                out_valid <= 1'b1;
                out_pc    <= inflight_pc;
                out_instr <= imem_rsp_data;
            end
            if ((state_q == ST_HOLD) && out_ready) begin
                out_valid <= 1'b0;
            end
            // Redirect overrides the sequential increment and any output.
            if (redirect_act) begin
                pc_q      <= redirect_aligned;
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch
// Self-checking bench for pc_fetch. Two instances share all inputs: one with
// the default reset PC and one starting at 0xFFFF_FFFC. A transaction-level
// reference model (outstanding/drop/holding flags plus a PC) predicts the
// outputs of both every cycle; a small memory model answers requests.
// ---------------------------------------------------------------------------
module tb_pc_fetch;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_ready;

    logic        req_valid1, out_valid1;
    logic [31:0] req_addr1, out_pc1, out_instr1;
    logic        req_valid2, out_valid2;
    logic [31:0] req_addr2, out_pc2, out_instr2;

    pc_fetch u_dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req_valid(req_valid1),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (req_addr1),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .out_valid     (out_valid1),
        .out_ready     (out_ready),
        .out_pc        (out_pc1),
        .out_instr     (out_instr1)
    );

    pc_fetch #(
        .RESET_PC(32'hFFFF_FFFC)
    ) u_dut_wrap (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req_valid(req_valid2),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (req_addr2),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .out_valid     (out_valid2),
        .out_ready     (out_ready),
        .out_pc        (out_pc2),
        .out_instr     (out_instr2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          started;  // first cycle after reset has passed
        bit          busy;     // a request is outstanding
        bit          drop;     // the outstanding response must be discarded
        bit          ov;       // an instruction is offered to decode
        logic [31:0] pc;
        logic [31:0] inflight;
        logic [31:0] opc;
        logic [31:0] oinstr;
    } model_t;

    model_t m1, m2;
    int     n_chk  = 0;
    int     n_fail = 0;

    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_data;
    int          lat_min, lat_max;

    logic [31:0] acc1[$];
    logic [31:0] acc2[$];
    logic [31:0] cons1[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic model_t minit(input logic [31:0] rpc);
        model_t m;
        m.started  = 1'b0;
        m.busy     = 1'b0;
        m.drop     = 1'b0;
        m.ov       = 1'b0;
        m.pc       = rpc;
        m.inflight = '0;
        m.opc      = '0;
        m.oinstr   = '0;
        return m;
    endfunction

    function automatic bit mreq(input model_t m);
        return m.started && !m.busy && !m.ov;
    endfunction

    function automatic model_t mstep(input model_t m, input bit redir, input logic [31:0] rpc,
                                     input bit rdy, input bit rsp, input logic [31:0] rdata,
                                     input bit ordy);
        model_t n = m;
        if (!m.started) begin
            n.started = 1'b1;
            return n;
        end
        if (rsp && m.busy) begin
            if (!m.drop && !redir) begin
                n.ov     = 1'b1;
                n.opc    = m.inflight;
                n.oinstr = rdata;
            end
            n.busy = 1'b0;
            n.drop = 1'b0;
        end
        if (m.ov && ordy) n.ov = 1'b0;
        if (mreq(m) && rdy) begin
            n.inflight = m.pc;
            n.pc       = m.pc + 32'd4;
            n.busy     = 1'b1;
        end
        if (redir) begin
            n.pc = {rpc[31:2], 2'b00};
            n.ov = 1'b0;
            if (n.busy) n.drop = 1'b1;
        end
        return n;
    endfunction

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic check_dut(input model_t m, input logic rv, input logic [31:0] ra,
                             input logic ov, input logic [31:0] opc, input logic [31:0] oi,
                             input string sfx);
        chk({"req_valid", sfx}, {31'b0, rv}, {31'b0, mreq(m)});
        if (mreq(m)) chk({"req_addr", sfx}, ra, m.pc);
        chk({"out_valid", sfx}, {31'b0, ov}, {31'b0, m.ov});
        if (m.ov) begin
            chk({"out_pc", sfx}, opc, m.opc);
            chk({"out_instr", sfx}, oi, m.oinstr);
        end
    endtask

    // One clock: check at negedge, drive inputs, advance models at posedge.
    task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy,
                        input bit ordy, input bit err);
        bit     acc;
        model_t n1, n2;
        @(negedge clk);
        check_dut(m1, req_valid1, req_addr1, out_valid1, out_pc1, out_instr1, "1");
        check_dut(m2, req_valid2, req_addr2, out_valid2, out_pc2, out_instr2, "2");
        if (out_valid1 && ordy) cons1.push_back(out_pc1);
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = rdy;
        out_ready      = ordy;
        imem_rsp_valid = (mem_busy && mem_cnt == 0) || (err && !mem_busy);
        imem_rsp_data  = mem_busy ? mem_data : $urandom;
        acc = req_valid1 && rdy;
        if (acc) begin
            acc1.push_back(req_addr1);
            acc2.push_back(req_addr2);
        end
        n1 = mstep(m1, redir, rpc, rdy, imem_rsp_valid, imem_rsp_data, ordy);
        n2 = mstep(m2, redir, rpc, rdy, imem_rsp_valid, imem_rsp_data, ordy);
        @(posedge clk);
        m1 = n1;
        m2 = n2;
        if (mem_busy && mem_cnt == 0) mem_busy = 1'b0;
        else if (mem_busy) mem_cnt--;
        if (acc) begin
            mem_busy = 1'b1;
            mem_cnt  = $urandom_range(lat_max, lat_min);
            mem_data = $urandom;
        end
        #1;
    endtask

    task automatic do_reset();
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        out_ready      = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("rst_req_valid", {31'b0, req_valid1}, 32'd0);
        chk("rst_req_addr", req_addr1, 32'h0000_0000);
        chk("rst_req_addr_wrap", req_addr2, 32'hFFFF_FFFC);
        chk("rst_out_valid", {31'b0, out_valid1}, 32'd0);
        chk("rst_out_pc", out_pc1, 32'd0);
        chk("rst_out_instr", out_instr1, 32'd0);
        chk("rst_out_valid_wrap", {31'b0, out_valid2}, 32'd0);
        @(posedge clk);
        #2;
        rst      = 1'b0;
        m1       = minit(32'h0000_0000);
        m2       = minit(32'hFFFF_FFFC);
        mem_busy = 1'b0;
        mem_cnt  = 0;
        mem_data = '0;
    endtask

    initial begin
        logic [31:0] p0, i0;
        rst = 1'b0;
        lat_min = 0;
        lat_max = 0;
        #1;
        do_reset();

        // Straight-line fetch: always ready, 1-cycle response, decode ready.
        acc1.delete(); acc2.delete(); cons1.delete();
        repeat (14) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        chk("seq_pc0", qat(cons1, 0), 32'h0);
        chk("seq_pc1", qat(cons1, 1), 32'h4);
        chk("seq_pc2", qat(cons1, 2), 32'h8);
        chk("wrap_addr0", qat(acc2, 0), 32'hFFFF_FFFC);
        chk("wrap_addr1", qat(acc2, 1), 32'h0000_0000);

        // Decode stalls for 5 cycles while an instruction is held.
        lat_max = 2;
        for (int i = 0; i < 20 && !m1.ov; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("hold_reached", {31'b0, out_valid1}, 32'd1);
        p0 = out_pc1;
        i0 = out_instr1;
        acc1.delete();
        repeat (5) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("stall_valid", {31'b0, out_valid1}, 32'd1);
        chk("stall_pc", out_pc1, p0);
        chk("stall_instr", out_instr1, i0);
        chk("stall_no_req", acc1.size(), 32'd0);
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);

        // Redirect while waiting for a response.
        lat_min = 2;
        lat_max = 2;
        for (int i = 0; i < 20 && !(m1.busy && !m1.drop); i++) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        chk("wait_reached", {31'b0, m1.busy}, 32'd1);
        acc1.delete(); cons1.delete();
        step(1'b1, 32'h0000_1003, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 30 && cons1.size() == 0; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        chk("wait_redir_addr", qat(acc1, 0), 32'h0000_1000);
        chk("wait_redir_outpc", qat(cons1, 0), 32'h0000_1000);

        // Redirect coinciding with the decode handshake.
        lat_min = 0;
        lat_max = 1;
        for (int i = 0; i < 20 && !m1.ov; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("hold_reached2", {31'b0, out_valid1}, 32'd1);
        acc1.delete(); cons1.delete();
        p0 = out_pc1;
        step(1'b1, 32'h0000_0200, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 30 && cons1.size() < 2; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        chk("hs_redir_consumed", qat(cons1, 0), p0);
        chk("hs_redir_addr", qat(acc1, 0), 32'h0000_0200);
        chk("hs_redir_next", qat(cons1, 1), 32'h0000_0200);

        // Reset while waiting; a redirect in the first cycle afterwards is ignored.
        lat_min = 2;
        lat_max = 2;
        for (int i = 0; i < 20 && !(m1.busy && !m1.drop); i++) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        chk("wait_reached2", {31'b0, m1.busy}, 32'd1);
        do_reset();
        acc1.delete();
        step(1'b1, 32'h0000_5550, 1'b1, 1'b1, 1'b0);
        repeat (4) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        chk("post_rst_addr", qat(acc1, 0), 32'h0000_0000);

        // Randomized traffic with occasional stray responses.
        lat_min = 0;
        lat_max = 3;
        repeat (800) begin
            step(($urandom % 10) == 0, $urandom, ($urandom % 10) < 7,
                 ($urandom % 10) < 6, ($urandom % 30) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter BUS_WIDTH, default 32: width of all address/PC buses.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 Parameter PC_INC, default 4: sequential PC increment.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 redirect_valid  in  1  branch/jump redirect request.
REQ-007 redirect_pc  in  BUS_WIDTH  redirect target.
REQ-008 imem_req_valid  out  1  instruction-memory request valid.
REQ-009 imem_req_ready  in  1  memory accepts request.
REQ-010 imem_req_addr  out  BUS_WIDTH  fetch address.
REQ-011 imem_rsp_valid  in  1  instruction returned (one per accepted request, in order).
REQ-012 imem_rsp_data  in  32  returned instruction word.
REQ-013 out_valid  out  1  fetched instruction valid toward decode.
REQ-014 out_ready  in  1  decode accepts.
REQ-015 out_pc  out  BUS_WIDTH  address of out_instr.
REQ-016 out_instr  out  32  fetched instruction.

Function
REQ-017 States SHALL be IDLE, REQ, WAIT, HOLD, DRAIN; at most one imem request outstanding.
REQ-018 IDLE -> REQ unconditionally on first clock after reset release; imem_req_valid SHALL be 0 in IDLE.
REQ-019 REQ: imem_req_valid=1, imem_req_addr=pc_q; on valid&ready: inflight_pc<=pc_q, pc_q<=pc_q+PC_INC, -> WAIT.
REQ-020 PC increment SHALL be modulo 2^BUS_WIDTH (32'hFFFF_FFFC + 4 = 32'h0000_0000), no carry out.
REQ-021 WAIT: on imem_rsp_valid: out_instr<=imem_rsp_data, out_pc<=inflight_pc, out_valid<=1, -> HOLD (out_valid rises cycle after response).
REQ-022 HOLD: out_valid, out_pc, out_instr SHALL stay stable until out_valid&out_ready; then out_valid<=0, -> REQ.
REQ-023 redirect_valid SHALL have priority over every other event in every non-IDLE state: pc_q<=redirect_pc with bits [1:0] forced to 0, out_valid<=0.
REQ-024 Redirect in REQ (without acceptance) or HOLD -> REQ; redirect in WAIT, or in REQ coinciding with request acceptance -> DRAIN.
REQ-025 DRAIN: imem_req_valid=0; next imem_rsp_valid is discarded (no out_valid), then -> REQ; a further redirect in DRAIN updates pc_q and stays in DRAIN.
REQ-026 Redirect coinciding with out handshake in HOLD: the handshake completes (instruction consumed), redirect still applied, -> REQ.
REQ-027 imem_rsp_valid in IDLE, REQ or HOLD is a protocol error and SHALL be ignored.
REQ-028 Redirect in IDLE SHALL be ignored.
REQ-029 Fetch-to-out latency: request accepted cycle N, response cycle N+k, out_valid high cycle N+k+1.

Reset
REQ-030 On rst=1: state=IDLE, pc_q=RESET_PC, inflight_pc=0, out_valid=0, out_pc=0, out_instr=0, imem_req_valid=0, immediately (asynchronous).
REQ-031 Reset mid-transaction SHALL abandon any in-flight request; memory side is reset in the same domain, so no stale response follows.

Structure
REQ-032 State encodings, RESET_PC default and PC_INC default SHALL live in shared package ev22_pkg.
REQ-033 PC+PC_INC SHALL be computed by one instance of sub-module adder (BUS_WIDTH-wide, b tied to PC_INC).
REQ-034 All outputs SHALL be registered or decoded from state only; no combinational path from inputs to outputs.

Verification
REQ-035 Reset, memory always ready, 1-cycle response, out_ready=1 -> out_pc sequence 0x0,0x4,0x8 with matching words.
REQ-036 out_ready held 0 for 5 cycles in HOLD -> out_valid/out_pc/out_instr stable, no new imem request issued.
REQ-037 Redirect to 0x0000_1003 while in WAIT -> next response dropped, next request address 0x0000_1000, next out_pc 0x1000.
REQ-038 Redirect to 0x200 and out handshake in same HOLD cycle -> current instruction consumed once, next request address 0x200.
REQ-039 RESET_PC=32'hFFFF_FFFC -> request addresses 0xFFFF_FFFC then 0x0000_0000.
REQ-040 rst asserted during WAIT -> all outputs zero same cycle, first request at RESET_PC two cycles after release.
